byte_unstriping: RTL and testbench

BYTE_UNSTRIPING -- requirements
Module: byte_unstriping

---
 rtl/byte_unstriping.sv | 160 ++++++++++++++++
 tb/tb_byte_unstriping.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/byte_unstriping.sv
// rtl/byte_unstriping.sv - four-lane to byte-stream unstriper with valid/ready handshakes
//
// Accepts a four-lane word, emits its 1, 2 or 4 active bytes one at a time in
// ascending or descending lane order, and takes the next word on the same edge
// as the last byte of the current one, so back-to-back words have no bubble.
//
// Optional feature macro: BU_SKIP_FILTER_EN
//    defined   - a selected byte equal to 8'hBC is dropped: it is never presented,
//                and the lane index moves past it in one cycle whatever OUT_READY is.
//    undefined - every byte is emitted, including 8'hBC.
//
// Ports
//    CLK        in   byte-rate clock, rising edge
//    RESET_L    in   asynchronous active-low reset
//    IN_ENB     in   block enable; 0 freezes all state and gates both handshakes
//    IN_LANE3-0 in   [7:0] lane bytes of the incoming word
//    IN_VALID   in   incoming word present
//    IN_READY   out  word accepted when IN_VALID && IN_READY at a rising edge
//    IN_MODO    in   [1:0] active lanes: 00 -> lane0, 01 -> lanes 0-1, 1x -> lanes 0-3
//    IN_DIR     in   0 -> lowest lane first, 1 -> highest active lane first
//    OUT_DATA   out  [7:0] current byte, 8'h00 when no word is held
//    OUT_VALID  out  OUT_DATA valid
//    OUT_READY  in   consumer ready; byte transfers when OUT_VALID && OUT_READY
//    OUT_CNT    out  [15:0] bytes delivered, wrapping
//    OUT_ERR    out  sticky flag, set when a word with IN_MODO=11 is accepted

module byte_unstriping (
   input  logic        CLK,
   input  logic        RESET_L,
   input  logic        IN_ENB,
   input  logic [7:0]  IN_LANE3,
   input  logic [7:0]  IN_LANE2,
   input  logic [7:0]  IN_LANE1,
   input  logic [7:0]  IN_LANE0,
   input  logic        IN_VALID,
   output logic        IN_READY,
   input  logic [1:0]  IN_MODO,
   input  logic        IN_DIR,
   output logic [7:0]  OUT_DATA,
   output logic        OUT_VALID,
   input  logic        OUT_READY,
   output logic [15:0] OUT_CNT,
   output logic        OUT_ERR
);

   localparam logic [7:0] SKIP_BYTE = 8'hBC;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  idx_q,   idx_d;
   logic [31:0] word_q,  word_d;
   logic [1:0]  modo_q,  modo_d;
   logic        dir_q,   dir_d;
   logic [15:0] cnt_q,   cnt_d;
   logic        err_q,   err_d;

   logic [1:0]  last_idx;
   logic [1:0]  sel_lane;
   logic [7:0]  sel_byte;
   logic        sending;
   logic        is_skip;
   logic        advance;
   logic        xfer;
   logic        last_adv;
   logic        in_ready;
   logic        accept;

   // Byte selection from the held word; the held mode and direction are used so
   // input changes during a word cannot disturb it.
   always_comb begin
      last_idx = 2'd3;
      case (modo_q)
         2'b00:   last_idx = 2'd0;
         2'b01:   last_idx = 2'd1;
         default: last_idx = 2'd3;
      endcase

      sel_lane = dir_q ? (last_idx - idx_q) : idx_q;
      sel_byte = word_q[{sel_lane, 3'b000} +: 8];
      sending  = (state_q == ST_SEND);

`ifdef BU_SKIP_FILTER_EN
      is_skip  = sending && (sel_byte == SKIP_BYTE);
`else
      is_skip  = 1'b0;
`endif

      // A skipped byte advances like a transferred one but is never counted.
      advance  = IN_ENB && sending && (is_skip || OUT_READY);
      xfer     = IN_ENB && sending && !is_skip && OUT_READY;
      last_adv = advance && (idx_q == last_idx);

      // Reset state is IDLE, so RESET_L gating keeps IN_READY low while reset is held.
      in_ready = RESET_L && IN_ENB && (!sending || last_adv);
      accept   = IN_VALID && in_ready;
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      word_d  = word_q;
      modo_d  = modo_q;
      dir_d   = dir_q;
      cnt_d   = cnt_q;
      err_d   = err_q;

      if (xfer) begin
         cnt_d = cnt_q + 16'd1;
      end

      if (accept) begin
         state_d = ST_SEND;
         idx_d   = 2'd0;
         word_d  = {IN_LANE3, IN_LANE2, IN_LANE1, IN_LANE0};
         modo_d  = IN_MODO;
         dir_d   = IN_DIR;
         if (IN_MODO == 2'b11) begin
            err_d = 1'b1;
         end
      end else if (advance) begin
         if (last_adv) begin
            state_d = ST_IDLE;
            idx_d   = 2'd0;
         end else begin
            idx_d   = idx_q + 2'd1;
         end
      end
   end

   always_ff @(posedge CLK or negedge RESET_L) begin
      if (!RESET_L) begin
         state_q <= ST_IDLE;
         idx_q   <= 2'd0;
         word_q  <= 32'd0;
         modo_q  <= 2'd0;
         dir_q   <= 1'b0;
         cnt_q   <= 16'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         word_q  <= word_d;
         modo_q  <= modo_d;
         dir_q   <= dir_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign IN_READY  = in_ready;
   assign OUT_VALID = IN_ENB && sending && !is_skip;
   assign OUT_DATA  = sending ? sel_byte : 8'h00;
   assign OUT_CNT   = cnt_q;
   assign OUT_ERR   = err_q;

endmodule

// File: tb/tb_byte_unstriping.sv
// tb/tb_byte_unstriping.sv - self-checking bench for byte_unstriping against a byte-queue model

module tb_byte_unstriping;

   logic        CLK = 1'b0;
   logic        RESET_L;
   logic        IN_ENB;
   logic [7:0]  IN_LANE3, IN_LANE2, IN_LANE1, IN_LANE0;
   logic        IN_VALID;
   logic        IN_READY;
   logic [1:0]  IN_MODO;
   logic        IN_DIR;
   logic [7:0]  OUT_DATA;
   logic        OUT_VALID;
   logic        OUT_READY;
   logic [15:0] OUT_CNT;
   logic        OUT_ERR;

`ifdef BU_SKIP_FILTER_EN
   localparam bit FILTER = 1'b1;
`else
   localparam bit FILTER = 1'b0;
`endif

   byte_unstriping dut (
      .CLK       (CLK),
      .RESET_L   (RESET_L),
      .IN_ENB    (IN_ENB),
      .IN_LANE3  (IN_LANE3),
      .IN_LANE2  (IN_LANE2),
      .IN_LANE1  (IN_LANE1),
      .IN_LANE0  (IN_LANE0),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .IN_MODO   (IN_MODO),
      .IN_DIR    (IN_DIR),
      .OUT_DATA  (OUT_DATA),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .OUT_CNT   (OUT_CNT),
      .OUT_ERR   (OUT_ERR)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_errors = 0;

   // Model: the bytes of the word in flight, in emission order.
   logic [7:0]  rem[$];
   logic [15:0] exp_cnt;
   logic        exp_err;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_clear();
      rem.delete();
      exp_cnt = 16'd0;
      exp_err = 1'b0;
   endtask

   // One clock cycle: drive inputs after the falling edge, check outputs, then
   // advance the model across the rising edge.
   task automatic step(input logic en, input logic v, input logic [31:0] w,
                       input logic [1:0] m, input logic d, input logic ordy);
      logic       h_skip;
      logic       e_valid, e_ready;
      logic [7:0] e_data;
      int         n;
      @(negedge CLK);
      IN_ENB    = en;
      IN_VALID  = v;
      {IN_LANE3, IN_LANE2, IN_LANE1, IN_LANE0} = w;
      IN_MODO   = m;
      IN_DIR    = d;
      OUT_READY = ordy;
      #1;
      if (rem.size() == 0) begin
         h_skip  = 1'b0;
         e_valid = 1'b0;
         e_data  = 8'h00;
         e_ready = en;
      end else begin
         e_data  = rem[0];
         h_skip  = FILTER && (rem[0] == 8'hBC);
         e_valid = en && !h_skip;
         e_ready = en && (rem.size() == 1) && (h_skip || ordy);
      end
      check_val("in_ready",  IN_READY,  e_ready);
      check_val("out_valid", OUT_VALID, e_valid);
      if (!h_skip) check_val("out_data", OUT_DATA, e_data);
      check_val("out_cnt",   OUT_CNT,   exp_cnt);
      check_val("out_err",   OUT_ERR,   exp_err);
      @(posedge CLK);
      if (en && rem.size() > 0 && (h_skip || ordy)) begin
         void'(rem.pop_front());
         if (!h_skip) exp_cnt = exp_cnt + 16'd1;
      end
      if (v && e_ready) begin
         rem.delete();
         n = (m == 2'b00) ? 1 : (m == 2'b01) ? 2 : 4;
         for (int i = 0; i < n; i++) begin
            int lane;
            lane = d ? (n - 1 - i) : i;
            rem.push_back(w[lane*8 +: 8]);
         end
         if (m == 2'b11) exp_err = 1'b1;
      end
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RESET_L  = 1'b0;
      IN_ENB   = 1'b1;
      IN_VALID = 1'b1;
      #1;
      check_val("rst_in_ready",  IN_READY,  1'b0);
      check_val("rst_out_valid", OUT_VALID, 1'b0);
      check_val("rst_out_data",  OUT_DATA,  8'h00);
      check_val("rst_out_cnt",   OUT_CNT,   16'h0000);
      check_val("rst_out_err",   OUT_ERR,   1'b0);
      repeat (2) @(negedge CLK);
      IN_VALID = 1'b0;
      RESET_L  = 1'b1;
      model_clear();
   endtask

   task automatic idle_steps(input int k);
      for (int i = 0; i < k; i++) step(1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 1'b1);
   endtask

   initial begin
      RESET_L   = 1'b0;
      IN_ENB    = 1'b0;
      IN_VALID  = 1'b0;
      {IN_LANE3, IN_LANE2, IN_LANE1, IN_LANE0} = 32'h0;
      IN_MODO   = 2'b00;
      IN_DIR    = 1'b0;
      OUT_READY = 1'b0;
      model_clear();
      do_reset();

      // Four lanes ascending.
      step(1'b1, 1'b1, 32'h44332211, 2'b10, 1'b0, 1'b1);
      idle_steps(5);
      check_val("four_lane_cnt", OUT_CNT, 16'd4);

      // Two lanes descending.
      do_reset();
      step(1'b1, 1'b1, 32'h44332211, 2'b01, 1'b1, 1'b1);
      idle_steps(3);
      check_val("two_lane_cnt", OUT_CNT, 16'd2);

      // Back-to-back single-lane words.
      step(1'b1, 1'b1, 32'h000000A5, 2'b00, 1'b0, 1'b1);
      step(1'b1, 1'b1, 32'h0000005A, 2'b00, 1'b0, 1'b1);
      step(1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 1'b1);
      idle_steps(2);

      // Consumer stall then enable low, mid-word, with mode/dir wiggling.
      step(1'b1, 1'b1, 32'hDDCCBBAA, 2'b10, 1'b0, 1'b1);
      step(1'b1, 1'b0, 32'h0, 2'b00, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 2'b01, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 32'h12345678, 2'b00, 1'b1, 1'b1);
      idle_steps(4);

      // Illegal mode, then reset after the first byte.
      step(1'b1, 1'b1, 32'h89ABCDEF, 2'b11, 1'b0, 1'b1);
      step(1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 1'b1);
      check_val("illegal_err", OUT_ERR, 1'b1);
      do_reset();
      step(1'b1, 1'b1, 32'h04030201, 2'b10, 1'b0, 1'b1);
      idle_steps(5);

      // Idle-byte pattern, with and without the filter.
      do_reset();
      step(1'b1, 1'b1, 32'h01BCBC02, 2'b10, 1'b0, 1'b1);
      idle_steps(5);
      check_val("bc_pattern_cnt", OUT_CNT, FILTER ? 16'd2 : 16'd4);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] w;
         w = $urandom;
         for (int b = 0; b < 4; b++) if ($urandom_range(0, 5) == 0) w[b*8 +: 8] = 8'hBC;
         step($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7, w,
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
